uart_rx: RTL

Asynchronous serial receiver, 8N1 style: start bit, `WORD_SIZE` data bits LSB first, one stop bit. It oversamples the `rx` line with the system clock and samples each bit at its midpoint. For each correctly framed word it emits a single-cycle `data_out_valid` pulse. It sits directly upstream of the message assembler and feeds that block's `data_in` / `data_in_valid` inputs unchanged.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_ff.sv | 26 ++
 rtl/uart_rx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and the future transmitter.
package uart_pkg;

   // 12 MHz system clock / 115200 baud.
   localparam int UART_CLKS_PER_BIT = 104;

   typedef enum logic [2:0] {
      SM_IDLE,
      SM_START,
      SM_DATA,
      SM_STOP,
      SM_BREAK
   } uart_state_t;

   // Width of a counter that must hold values 0 .. n-1 (never narrower than 1 bit).
   function automatic int uart_cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: N-stage single-bit synchroniser for an asynchronous input.
module sync_ff #(
   parameter int   N         = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic [N-1:0] r_sync;

   // Shift the raw input through N flops; only the last stage is safe to use.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync <= {N{RESET_VAL}};
      end else begin
         // NOTE: non-blocking assignment so every stage takes the previous stage's old value.
         r_sync <= {r_sync[N-2:0], i_d};
      end
   end

   assign o_q = r_sync[N-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver, oversampled by the system clock,
// sampling every bit at its midpoint.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,  // at least 4
   parameter int WORD_SIZE    = 8,
   parameter int SYNC_STAGES  = 2                   // at least 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [WORD_SIZE-1:0] data_out,
   output logic                 data_out_valid,
   output logic                 frame_error
);

   localparam int CTR_W = uart_cnt_width(CLKS_PER_BIT);
   localparam int IDX_W = uart_cnt_width(WORD_SIZE);

   // Terminal counts: a full bit period, half a bit period, and the last data bit.
   localparam logic [CTR_W-1:0] LP_CTR_BIT_LAST  = CTR_W'(CLKS_PER_BIT - 1);
   localparam logic [CTR_W-1:0] LP_CTR_HALF_LAST = CTR_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CTR_W-1:0] LP_CTR_ONE       = CTR_W'(1);
   localparam logic [IDX_W-1:0] LP_IDX_LAST      = IDX_W'(WORD_SIZE - 1);
   localparam logic [IDX_W-1:0] LP_IDX_ONE       = IDX_W'(1);

   logic                   w_rxs;
   uart_state_t            r_state;
   logic [CTR_W-1:0]       r_ctr;
   logic [IDX_W-1:0]       r_bit_idx;
   logic [WORD_SIZE-1:0]   r_shreg;
   logic [WORD_SIZE-1:0]   r_data_out;
   logic                   r_valid;
   logic                   r_ferr;
   logic [SYNC_STAGES-1:0] r_flush;
   logic                   w_sync_primed;

   sync_ff #(
      .N         (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (rx),
      .o_q   (w_rxs)
   );

   // After reset the synchroniser holds its idle-high reset value for
   // SYNC_STAGES cycles, which says nothing about the real line. This shift
   // register fills with ones as those stale values drain out, so SM_BREAK
   // only releases on a genuinely high line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_flush <= '0;
      end else begin
         r_flush <= {r_flush[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign w_sync_primed = r_flush[SYNC_STAGES-1];

   // Frame state machine: bit timing, data shifting and registered output pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= SM_BREAK;
         r_ctr      <= '0;
         r_bit_idx  <= '0;
         r_shreg    <= '0;
         r_data_out <= '0;
         r_valid    <= 1'b0;
         r_ferr     <= 1'b0;
      end else begin
         // NOTE: pulse outputs default low every cycle; branches below raise them for one cycle only.
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;

         case (r_state)
            SM_IDLE: begin
               r_ctr <= '0;
               if (!w_rxs) begin
                  r_state <= SM_START;
               end
            end

            // Wait half a bit, then confirm the start bit is still low.
            SM_START: begin
               if (r_ctr == LP_CTR_HALF_LAST) begin
                  r_ctr     <= '0;
                  r_bit_idx <= '0;
                  r_state   <= w_rxs ? SM_IDLE : SM_DATA;
               end else begin
                  r_ctr <= r_ctr + LP_CTR_ONE;
               end
            end

            // Sample one data bit per bit period, shifting in from the MSB so
            // the first (least significant) bit ends up at bit 0.
            SM_DATA: begin
               if (r_ctr == LP_CTR_BIT_LAST) begin
                  r_ctr   <= '0;
                  r_shreg <= {w_rxs, r_shreg[WORD_SIZE-1:1]};
                  if (r_bit_idx == LP_IDX_LAST) begin
                     r_state <= SM_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + LP_IDX_ONE;
                  end
               end else begin
                  r_ctr <= r_ctr + LP_CTR_ONE;
               end
            end

            // Mid-stop-bit sample: high publishes the word, low flags a framing
            // error. Leaving at mid-stop lets an immediately following start
            // bit be caught.
            SM_STOP: begin
               if (r_ctr == LP_CTR_BIT_LAST) begin
                  r_ctr <= '0;
                  if (w_rxs) begin
                     r_data_out <= r_shreg;
                     r_valid    <= 1'b1;
                     r_state    <= SM_IDLE;
                  end else begin
                     r_ferr  <= 1'b1;
                     r_state <= SM_BREAK;
                  end
               end else begin
                  r_ctr <= r_ctr + LP_CTR_ONE;
               end
            end

            // A line held low is not a new start bit; wait for it to go high.
            SM_BREAK: begin
               r_ctr <= '0;
               if (w_rxs && w_sync_primed) begin
                  r_state <= SM_IDLE;
               end
            end

            default: begin
               r_ctr   <= '0;
               r_state <= SM_BREAK;
            end
         endcase
      end
   end

   assign data_out       = r_data_out;
   assign data_out_valid = r_valid;
   assign frame_error    = r_ferr;

endmodule
